// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
//   Shared types and constants for the 1101 byte-stream detector slice.
//   - ctrl_state_t : stream controller states (serialiser / halt handling)
//   - det_state_t  : serial 1101 Moore detector states
//   - PATTERN      : the bit pattern the detector core recognises, oldest bit
//                    in the MSB
// -----------------------------------------------------------------------------
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HALT  = 2'd2
    } ctrl_state_t;

    typedef enum logic [2:0] {
        D_IDLE = 3'd0,
        D_S1   = 3'd1,
        D_S11  = 3'd2,
        D_S110 = 3'd3,
        D_DET  = 3'd4
    } det_state_t;

    localparam int                     PATTERN_W = 4;
    localparam logic [PATTERN_W-1:0]   PATTERN   = 4'b1101;

endpackage

// File: rtl/seq1101_moore_core.sv
// -----------------------------------------------------------------------------
// seq1101_moore_core
//   Fully overlapping serial 1101 detector. The state only advances on cycles
//   where bit_en is high, so gaps between bits (and word boundaries upstream)
//   do not disturb a partial match.
//
//   state  | meaning
//   -------+---------------------------------------------
//   D_IDLE | no useful prefix seen
//   D_S1   | last bit seen was 1
//   D_S11  | last bits seen were 11
//   D_S110 | last bits seen were 110
//   D_DET  | 1101 just completed
//
// Ports
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   bit_en  in   bit_in is valid and is consumed this cycle
//   bit_in  in   serial bit
//   clr     in   synchronous return to D_IDLE (overrides bit_en)
//   match   out  combinational match event: the bit consumed this cycle
//                completes 1101; the owner registers it into a pulse
// -----------------------------------------------------------------------------
module seq1101_moore_core
    import seq_detect_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic bit_en,
    input  logic bit_in,
    input  logic clr,
    output logic match
);

    det_state_t r_state;
    det_state_t w_state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= D_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = D_IDLE;
        end else if (bit_en) begin
            case (r_state)
                D_IDLE:  w_state_nxt = bit_in ? D_S1   : D_IDLE;
                D_S1:    w_state_nxt = bit_in ? D_S11  : D_IDLE;
                D_S11:   w_state_nxt = bit_in ? D_S11  : D_S110;
                D_S110:  w_state_nxt = bit_in ? D_DET  : D_IDLE;
                D_DET:   w_state_nxt = bit_in ? D_S11  : D_IDLE;
                default: w_state_nxt = D_IDLE;
            endcase
        end
    end

    // Taken from the transition into D_DET rather than from D_DET itself, so
    // a match is reported exactly once even if the stream pauses after it.
    assign match = bit_en & (r_state == D_S110) & (bit_in == PATTERN[0]);

endmodule

// File: rtl/seq_detect_stream_ctrl.sv
// -----------------------------------------------------------------------------
// seq_detect_stream_ctrl
//   Byte-stream front end for the serial 1101 detector. Words are taken over a
//   valid/ready handshake, serialised MSB-first into seq1101_moore_core, and
//   matches are counted. When the count reaches the programmed threshold a
//   sticky flag is raised and intake halts until software pulses clear.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no word in flight; ready when enabled
//   SHIFT | presenting one bit per cycle; ready again on the last bit
//   HALT  | threshold reached; intake stopped until clear
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   s_valid      in   producer has a word on s_data
//   s_data       in   word to scan (DATA_W bits, sent MSB-first)
//   s_ready      out  a word is taken this cycle if s_valid is also high
//   enable       in   level; 0 stops new words, the word in flight finishes
//   clear        in   sync pulse: zero count/flag, drop word, reset detector
//   threshold    in   count that sets thresh_hit; 0 disables the flag
//   ser_bit      out  bit presented to the detector
//   ser_valid    out  ser_bit is consumed this cycle
//   match_pulse  out  one-cycle pulse per detected 1101
//   match_count  out  saturating match count since reset/clear
//   thresh_hit   out  sticky threshold flag
//   busy         out  a word is in flight
// -----------------------------------------------------------------------------
module seq_detect_stream_ctrl
    import seq_detect_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              enable,
    input  logic              clear,
    input  logic [CNT_W-1:0]  threshold,
    output logic              ser_bit,
    output logic              ser_valid,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              thresh_hit,
    output logic              busy
);

    localparam int                BCNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] w_shreg_nxt;
    logic [BCNT_W-1:0] r_bit_cnt;
    logic [BCNT_W-1:0] w_bit_cnt_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              r_thresh_hit;
    logic              w_thresh_nxt;
    logic              w_thresh_rise;
    logic              r_match_pulse;
    logic              w_in_shift;
    logic              w_last_bit;
    logic              w_xfer;
    logic              w_match;

    assign w_in_shift = (r_state == SHIFT);
    assign w_last_bit = (r_bit_cnt == LAST_BIT);

    // rst_n is folded in so the producer never sees ready while the block is
    // held in reset.
    always_comb begin
        s_ready = 1'b0;
        case (r_state)
            IDLE:    s_ready = rst_n & enable & ~clear;
            SHIFT:   s_ready = rst_n & enable & ~clear & w_last_bit;
            default: s_ready = 1'b0;
        endcase
    end

    assign w_xfer    = s_valid & s_ready;
    assign ser_valid = w_in_shift;
    assign ser_bit   = w_in_shift & r_shreg[DATA_W-1];
    assign busy      = w_in_shift;

    seq1101_moore_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .bit_en (ser_valid),
        .bit_in (ser_bit),
        .clr    (clear),
        .match  (w_match)
    );

    always_comb begin
        w_count_nxt = r_count;
        if (w_match && (r_count != CNT_MAX)) begin
            w_count_nxt = r_count + CNT_W'(1);
        end
    end

    // Evaluated every cycle against the live threshold, so lowering the
    // threshold below the current count also trips the flag.
    assign w_thresh_nxt  = r_thresh_hit | ((threshold != '0) & (w_count_nxt >= threshold));
    assign w_thresh_rise = w_thresh_nxt & ~r_thresh_hit;

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        if (clear) begin
            w_state_nxt   = IDLE;
            w_shreg_nxt   = '0;
            w_bit_cnt_nxt = '0;
        end else if (w_thresh_rise) begin
            // Whatever is left of the current word (or a word taken this same
            // cycle) is discarded.
            w_state_nxt   = HALT;
            w_shreg_nxt   = '0;
            w_bit_cnt_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        w_state_nxt   = SHIFT;
                        w_shreg_nxt   = s_data;
                        w_bit_cnt_nxt = '0;
                    end
                end
                SHIFT: begin
                    if (w_last_bit) begin
                        if (w_xfer) begin
                            w_shreg_nxt   = s_data;
                            w_bit_cnt_nxt = '0;
                        end else begin
                            w_state_nxt   = IDLE;
                            w_shreg_nxt   = '0;
                            w_bit_cnt_nxt = '0;
                        end
                    end else begin
                        w_shreg_nxt   = r_shreg << 1;
                        w_bit_cnt_nxt = r_bit_cnt + BCNT_W'(1);
                    end
                end
                HALT: begin
                    w_state_nxt = HALT;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_shreg       <= '0;
            r_bit_cnt     <= '0;
            r_count       <= '0;
            r_thresh_hit  <= 1'b0;
            r_match_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shreg       <= w_shreg_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_count       <= clear ? '0 : w_count_nxt;
            r_thresh_hit  <= clear ? 1'b0 : w_thresh_nxt;
            r_match_pulse <= w_match & ~clear;
        end
    end

    assign match_pulse = r_match_pulse;
    assign match_count = r_count;
    assign thresh_hit  = r_thresh_hit;

endmodule
